// File: rtl/sum_frame_checker.sv
// sum_frame_checker
// Sequential checker for the 3-bit adder stage. Over a frame of frame_len
// accepted samples it accumulates the comb-path sum (saturating), counts
// samples where the event-sensitive sum differs from it (saturating), records
// the index of the first mismatch, and presents the result as a registered
// report on a valid/ready port.

module sum_frame_checker #(
  parameter int SUM_W = 4,
  parameter int ACC_W = 12,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [CNT_W-1:0] frame_len,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [SUM_W-1:0] sum_a,
  input  logic [SUM_W-1:0] sum_c,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] acc_sum,
  output logic [CNT_W-1:0] mismatch_cnt,
  output logic [CNT_W-1:0] first_mis_idx,
  output logic             mis_seen,
  output logic             busy
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCUM,
    S_DONE
  } state_e;

  state_e           state_q,     state_d;
  logic [CNT_W-1:0] len_q,       len_d;
  logic [CNT_W-1:0] idx_q,       idx_d;
  logic [ACC_W-1:0] acc_q,       acc_d;
  logic [CNT_W-1:0] mis_cnt_q,   mis_cnt_d;
  logic [CNT_W-1:0] first_q,     first_d;
  logic             seen_q,      seen_d;
  logic             in_ready_q,  in_ready_d;
  logic             out_valid_q, out_valid_d;
  logic             busy_q,      busy_d;

  logic             accept;
  logic [ACC_W:0]   acc_ext;
  logic [ACC_W-1:0] acc_sat;
  logic [CNT_W-1:0] last_idx;

  // Accept only while the registered ready is high; ready mirrors ACCUM.
  assign accept   = in_valid && in_ready_q;
  // One extra bit on the adder exposes the carry used for clamping.
  assign acc_ext  = {1'b0, acc_q} + {{(ACC_W + 1 - SUM_W){1'b0}}, sum_c};
  assign acc_sat  = acc_ext[ACC_W] ? {ACC_W{1'b1}} : acc_ext[ACC_W-1:0];
  assign last_idx = len_q - CNT_W'(1);

  // Next-state and report-update logic for the frame FSM.
  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves
    // one unassigned, which would otherwise infer a latch.
    state_d   = state_q;
    len_d     = len_q;
    idx_d     = idx_q;
    acc_d     = acc_q;
    mis_cnt_d = mis_cnt_q;
    first_d   = first_q;
    seen_d    = seen_q;

    unique case (state_q)
      S_IDLE: begin
        if (start && (frame_len != '0)) begin
          len_d     = frame_len;
          idx_d     = '0;
          acc_d     = '0;
          mis_cnt_d = '0;
          first_d   = '0;
          seen_d    = 1'b0;
          state_d   = S_ACCUM;
        end
      end
      S_ACCUM: begin
        if (accept) begin
          acc_d = acc_sat;
          if (sum_a != sum_c) begin
            if (mis_cnt_q != {CNT_W{1'b1}}) begin
              mis_cnt_d = mis_cnt_q + CNT_W'(1);
            end
            if (!seen_q) begin
              first_d = idx_q;
              seen_d  = 1'b1;
            end
          end
          idx_d = idx_q + CNT_W'(1);
          if (idx_q == last_idx) begin
            state_d = S_DONE;
          end
        end
      end
      S_DONE: begin
        if (out_valid_q && out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Handshake flags are derived from the next state so they are registered
  // yet line up with the state they describe.
  assign in_ready_d  = (state_d == S_ACCUM);
  assign out_valid_d = (state_d == S_DONE);
  assign busy_d      = (state_d != S_IDLE);

  // State and report registers; reset discards any partial frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      len_q       <= '0;
      idx_q       <= '0;
      acc_q       <= '0;
      mis_cnt_q   <= '0;
      first_q     <= '0;
      seen_q      <= 1'b0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // from before this edge, independent of statement order.
      state_q     <= state_d;
      len_q       <= len_d;
      idx_q       <= idx_d;
      acc_q       <= acc_d;
      mis_cnt_q   <= mis_cnt_d;
      first_q     <= first_d;
      seen_q      <= seen_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign in_ready      = in_ready_q;
  assign out_valid     = out_valid_q;
  assign busy          = busy_q;
  assign acc_sum       = acc_q;
  assign mismatch_cnt  = mis_cnt_q;
  assign first_mis_idx = first_q;
  assign mis_seen      = seen_q;

endmodule

// File: tb/tb_sum_frame_checker.sv
// Testbench for sum_frame_checker: table of frames with expected reports,
// pushed to a scoreboard queue at frame start and compared when the report
// appears. A second instance with narrow widths shares all inputs and
// exercises accumulator and counter saturation.

module tb_sum_frame_checker;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [7:0] frame_len = '0;
  logic       in_valid = 1'b0;
  logic [3:0] sum_a = '0;
  logic [3:0] sum_c = '0;
  logic       out_ready = 1'b0;

  logic        in_ready, out_valid, mis_seen, busy;
  logic [11:0] acc_sum;
  logic [7:0]  mismatch_cnt, first_mis_idx;

  logic        s_in_ready, s_out_valid, s_mis_seen, s_busy;
  logic [4:0]  s_acc_sum;
  logic [2:0]  s_mismatch_cnt, s_first_mis_idx;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sum_frame_checker dut (
    .clk(clk), .rst_n(rst_n), .start(start), .frame_len(frame_len),
    .in_valid(in_valid), .in_ready(in_ready), .sum_a(sum_a), .sum_c(sum_c),
    .out_valid(out_valid), .out_ready(out_ready), .acc_sum(acc_sum),
    .mismatch_cnt(mismatch_cnt), .first_mis_idx(first_mis_idx),
    .mis_seen(mis_seen), .busy(busy)
  );

  sum_frame_checker #(.SUM_W(4), .ACC_W(5), .CNT_W(3)) dut_small (
    .clk(clk), .rst_n(rst_n), .start(start), .frame_len(frame_len[2:0]),
    .in_valid(in_valid), .in_ready(s_in_ready), .sum_a(sum_a), .sum_c(sum_c),
    .out_valid(s_out_valid), .out_ready(out_ready), .acc_sum(s_acc_sum),
    .mismatch_cnt(s_mismatch_cnt), .first_mis_idx(s_first_mis_idx),
    .mis_seen(s_mis_seen), .busy(s_busy)
  );

  typedef struct {
    int         len;
    logic [3:0] sa [8];
    logic [3:0] sc [8];
    int         gap;
    int         hold;
    bit         mid_start;
    int         acc;
    int         cnt;
    int         first;
    int         seen;
    int         s_acc;
    int         s_cnt;
  } frame_t;

  frame_t vecs [6];
  frame_t exp_q [$];

  task automatic check(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one sample and hold it until an edge where in_ready was high.
  task automatic send(input logic [3:0] a, input logic [3:0] c);
    logic rdy;
    int   n;
    n = 0;
    in_valid = 1'b1;
    sum_a = a;
    sum_c = c;
    do begin
      rdy = in_ready;
      tick();
      n++;
    end while (!rdy && n < 50);
    if (!rdy) check("accept_timeout", 0, 1);
    in_valid = 1'b0;
  endtask

  task automatic run_vec(input frame_t v);
    frame_t e;
    exp_q.push_back(v);
    frame_len = 8'(v.len);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("busy_after_start", int'(busy), 1);
    check("in_ready_first_accum", int'(in_ready), 1);

    for (int i = 0; i < v.len; i++) begin
      send(v.sa[i], v.sc[i]);
      if (i < v.len - 1) begin
        check("no_early_report", int'(out_valid), 0);
        if (v.mid_start && i == 0) begin
          start = 1'b1;
          frame_len = 8'd1;
          tick();
          start = 1'b0;
          frame_len = 8'(v.len);
          check("mid_start_busy", int'(busy), 1);
          check("mid_start_ready", int'(in_ready), 1);
        end
        repeat (v.gap) tick();
      end
    end

    check("report_latency", int'(out_valid), 1);
    check("in_ready_drop", int'(in_ready), 0);

    e = exp_q.pop_front();
    check("acc_sum", int'(acc_sum), e.acc);
    check("mismatch_cnt", int'(mismatch_cnt), e.cnt);
    check("first_mis_idx", int'(first_mis_idx), e.first);
    check("mis_seen", int'(mis_seen), e.seen);
    check("small_acc_sum", int'(s_acc_sum), e.s_acc);
    check("small_mismatch_cnt", int'(s_mismatch_cnt), e.s_cnt);

    for (int h = 0; h < v.hold; h++) begin
      tick();
      check("hold_out_valid", int'(out_valid), 1);
      check("hold_acc_sum", int'(acc_sum), e.acc);
      check("hold_mismatch_cnt", int'(mismatch_cnt), e.cnt);
      check("hold_first_mis_idx", int'(first_mis_idx), e.first);
      check("hold_in_ready", int'(in_ready), 0);
    end

    // Handshake with a start pulse in the same cycle: the start must be dropped.
    out_ready = 1'b1;
    start = 1'b1;
    frame_len = 8'd2;
    tick();
    out_ready = 1'b0;
    start = 1'b0;
    check("handshake_out_valid", int'(out_valid), 0);
    check("handshake_busy", int'(busy), 0);
    check("report_visible_idle", int'(acc_sum), e.acc);
    tick();
    check("handshake_start_ignored", int'(busy), 0);
  endtask

  initial begin
    vecs[0] = '{len: 4, sa: '{3, 7, 14, 0, 0, 0, 0, 0}, sc: '{3, 7, 14, 0, 0, 0, 0, 0},
                gap: 0, hold: 0, mid_start: 1'b0,
                acc: 24, cnt: 0, first: 0, seen: 0, s_acc: 24, s_cnt: 0};
    vecs[1] = '{len: 5, sa: '{2, 2, 5, 2, 1, 0, 0, 0}, sc: '{2, 2, 9, 2, 6, 0, 0, 0},
                gap: 0, hold: 0, mid_start: 1'b0,
                acc: 21, cnt: 2, first: 2, seen: 1, s_acc: 21, s_cnt: 2};
    vecs[2] = '{len: 3, sa: '{1, 4, 6, 0, 0, 0, 0, 0}, sc: '{1, 5, 6, 0, 0, 0, 0, 0},
                gap: 2, hold: 5, mid_start: 1'b0,
                acc: 12, cnt: 1, first: 1, seen: 1, s_acc: 12, s_cnt: 1};
    vecs[3] = '{len: 4, sa: '{15, 15, 15, 15, 0, 0, 0, 0}, sc: '{15, 15, 15, 15, 0, 0, 0, 0},
                gap: 0, hold: 0, mid_start: 1'b0,
                acc: 60, cnt: 0, first: 0, seen: 0, s_acc: 31, s_cnt: 0};
    vecs[4] = '{len: 7, sa: '{0, 0, 0, 0, 0, 0, 0, 0}, sc: '{15, 15, 15, 15, 15, 15, 15, 0},
                gap: 0, hold: 1, mid_start: 1'b0,
                acc: 105, cnt: 7, first: 0, seen: 1, s_acc: 31, s_cnt: 7};
    vecs[5] = '{len: 3, sa: '{5, 5, 5, 0, 0, 0, 0, 0}, sc: '{5, 6, 5, 0, 0, 0, 0, 0},
                gap: 0, hold: 0, mid_start: 1'b1,
                acc: 16, cnt: 1, first: 1, seen: 1, s_acc: 16, s_cnt: 1};

    // Reset state
    #12;
    check("rst_in_ready", int'(in_ready), 0);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_acc_sum", int'(acc_sum), 0);
    check("rst_mis_seen", int'(mis_seen), 0);
    rst_n = 1'b1;
    tick();

    foreach (vecs[i]) run_vec(vecs[i]);

    // start with frame_len=0 is ignored; previous report stays visible
    frame_len = 8'd0;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    check("len0_busy", int'(busy), 0);
    check("len0_in_ready", int'(in_ready), 0);
    check("len0_report_kept", int'(acc_sum), 16);

    // Reset mid-frame after 2 of 4 samples
    frame_len = 8'd4;
    start = 1'b1;
    tick();
    start = 1'b0;
    send(4'd3, 4'd3);
    send(4'd2, 4'd9);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_busy", int'(busy), 0);
    check("midrst_in_ready", int'(in_ready), 0);
    check("midrst_out_valid", int'(out_valid), 0);
    check("midrst_acc_sum", int'(acc_sum), 0);
    check("midrst_mismatch_cnt", int'(mismatch_cnt), 0);
    check("midrst_mis_seen", int'(mis_seen), 0);
    check("midrst_small_acc", int'(s_acc_sum), 0);
    #4 rst_n = 1'b1;
    tick();
    run_vec('{len: 1, sa: '{4, 0, 0, 0, 0, 0, 0, 0}, sc: '{4, 0, 0, 0, 0, 0, 0, 0},
              gap: 0, hold: 0, mid_start: 1'b0,
              acc: 4, cnt: 0, first: 0, seen: 0, s_acc: 4, s_cnt: 0});

    check("scoreboard_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/sum_frame_checker.md
Name: sum_frame_checker

Overview:
- Downstream consumer of the 3-bit adder stage. Takes both of its 4-bit sum outputs: the event-sensitive path (sum_a) and the comb path (sum_c).
- Over a frame of N accepted samples it accumulates sum_c and counts samples where sum_a differs from sum_c. It also records the index of the first mismatch.
- It presents a frame report on a valid/ready output port. This is the sequential checker stage that turns sensitivity-list discrepancies into countable results.

Parameters:
- SUM_W, 4, width of each incoming sum.
- ACC_W, 12, width of the frame accumulator.
- CNT_W, 8, width of frame length, sample index and mismatch counter.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  one-cycle pulse that begins a frame; sampled only in IDLE.
- frame_len  input  CNT_W  number of samples in the frame; latched on an accepted start.
- in_valid  input  1  sum pair valid.
- in_ready  output  1  block can accept a sum pair.
- sum_a  input  SUM_W  sum from the event-sensitive path.
- sum_c  input  SUM_W  sum from the comb path (reference value).
- out_valid  output  1  frame report valid.
- out_ready  input  1  report consumer ready.
- acc_sum  output  ACC_W  saturating sum of sum_c over the frame.
- mismatch_cnt  output  CNT_W  number of samples with sum_a != sum_c (saturating).
- first_mis_idx  output  CNT_W  0-based index of the first mismatching sample; 0 if none.
- mis_seen  output  1  at least one mismatch occurred in the frame.
- busy  output  1  FSM not in IDLE.

Behaviour:
- Clock and reset: one clock, clk; reset is asynchronous and active-low, rst_n.
- Reset values: FSM=IDLE; in_ready=0, out_valid=0, busy=0; acc_sum=0, mismatch_cnt=0, first_mis_idx=0, mis_seen=0; internal sample counter=0, latched length=0.
- All outputs are registered; none is combinational from inputs.
- FSM states: IDLE, ACCUM, DONE.
- IDLE:
  - in_ready=0.
  - start=1 with frame_len!=0: latch frame_len, clear acc_sum, mismatch_cnt, first_mis_idx, mis_seen and the sample counter, then go to ACCUM next cycle.
  - start=1 with frame_len=0: ignored; stay in IDLE; report registers untouched.
- ACCUM:
  - in_ready=1 (registered; asserted from the first ACCUM cycle).
  - Accept occurs when in_valid && in_ready. On each accept:
    - acc_sum += zero-extended sum_c, clamped at 2^ACC_W-1.
    - If sum_a!=sum_c: mismatch_cnt += 1, clamped at 2^CNT_W-1. If mis_seen was 0, set first_mis_idx=current index and mis_seen=1.
    - Index increments.
  - Accepting sample index length-1 moves to DONE. in_ready drops the cycle after that accept, so no extra sample is taken.
  - in_valid=0 cycles are stalls: no state change.
- DONE:
  - out_valid=1, starting the cycle after the last accept (report latency 1 cycle).
  - Report outputs hold stable while out_valid && !out_ready.
  - out_valid && out_ready → IDLE next cycle; out_valid=0.
  - Report values remain visible in IDLE until the next accepted start clears them.
- start is ignored in ACCUM and DONE, including in the same cycle as the report handshake.
- Report handshake and a new start cannot overlap: start is honoured only once IDLE is reached.
- Reset mid-frame: immediate return to reset values. Partial frame is discarded; no report is produced.
- busy=1 in ACCUM and DONE.
- Widths: sum inputs are unsigned. The comparison is full SUM_W bits; X or Z on sum_a counts as a mismatch only as evaluated by 2-state logic (the bench drives 2-state values).

Test Plan:
- Clean frame: start, frame_len=4; sum pairs (3,3),(7,7),(14,14),(0,0) back-to-back → out_valid one cycle after 4th accept; acc_sum=24, mismatch_cnt=0, mis_seen=0, first_mis_idx=0.
- Mismatch capture: frame_len=5; mismatches at indices 2 and 4 (sum_a=5,sum_c=9 and sum_a=1,sum_c=6), other pairs (2,2) → mismatch_cnt=2, first_mis_idx=2, mis_seen=1, acc_sum=21.
- Backpressure and stalls: frame_len=3 with in_valid gaps of 2 cycles; out_ready held 0 for 5 cycles → report stable all 5 cycles; in_ready=0 throughout DONE; IDLE one cycle after out_ready=1.
- Saturation: ACC_W=5, frame_len=4, sum_c=15 each → acc_sum=31 (not 60 mod 32). CNT_W=3, frame_len=7 all mismatching → mismatch_cnt=7.
- Ignored starts: start with frame_len=0 → stays IDLE, busy=0. start pulsed mid-ACCUM → frame length unchanged, counts unaffected.
- Reset mid-frame: rst_n low after 2 of 4 samples → all outputs 0 asynchronously. Following frame_len=1 with (4,4) → acc_sum=4, out_valid one cycle after the accept.
